// File: rtl/cpu_out_fifo_if.sv
// -----------------------------------------------------------------------------
// cpu_out_fifo_if
//   Consumer-side valid/ready handshake of the CPU output FIFO.
//
//   Signals:
//     outValid  FIFO head is valid (driven by the FIFO)
//     outData   FIFO head word     (driven by the FIFO)
//     outReady  consumer accepts the head this cycle (driven by the consumer)
//
//   Modports:
//     master  the FIFO side (drives outValid/outData, samples outReady)
//     slave   the consumer side
// -----------------------------------------------------------------------------
interface cpu_out_fifo_if #(
    parameter int WIDTH = 36
);
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic             outReady;

    modport master (
        output outValid,
        output outData,
        input  outReady
    );

    modport slave (
        input  outValid,
        input  outData,
        output outReady
    );
endinterface

// File: rtl/cpu_out_fifo.sv
// -----------------------------------------------------------------------------
// cpu_out_fifo
//   Output port of the pipelined CPU. Every write-back outFlag pulse pushes the
//   word on `out` into a DEPTH-entry first-word-fall-through FIFO, which a
//   consumer drains over a valid/ready handshake. stallOut is raised one entry
//   before the FIFO is full so the hazard unit can stop the CPU with one word
//   still in flight. Dropped pushes are flagged (sticky overflow) and counted.
//
//   Ports:
//     clock, reset        single clock; synchronous active-low reset
//     outFlag, out        CPU push strobe and word
//     stallOut            stall request to the hazard unit (count >= DEPTH-1)
//     cons                consumer handshake (cpu_out_fifo_if.master)
//     count               occupancy 0..DEPTH
//     overflow            sticky: at least one push was dropped
//     pushCount           accepted pushes, wraps
//     dropCount           dropped pushes, saturates
//
//   Optional build macro OUT_CHECK_EN adds an output checker:
//     expectData          word the consumer expects at the next pop
//     checkIndex          number of words popped so far
//     mismatch            sticky: a popped word differed from expectData
//     firstMismatchIndex  checkIndex value of the first differing pop
// -----------------------------------------------------------------------------
module cpu_out_fifo #(
    parameter int WIDTH     = 36,
    parameter int DEPTH     = 8,
    parameter int ADDRWIDTH = 3,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 outFlag,
    input  logic [WIDTH-1:0]     out,
    output logic                 stallOut,
    cpu_out_fifo_if.master       cons,
    output logic [ADDRWIDTH:0]   count,
    output logic                 overflow,
    output logic [CNTWIDTH-1:0]  pushCount,
    output logic [CNTWIDTH-1:0]  dropCount
`ifdef OUT_CHECK_EN
    ,
    input  logic [WIDTH-1:0]     expectData,
    output logic [CNTWIDTH-1:0]  checkIndex,
    output logic                 mismatch,
    output logic [CNTWIDTH-1:0]  firstMismatchIndex
`endif
);

    localparam logic [ADDRWIDTH:0] FULL_CNT = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] NEAR_CNT = (ADDRWIDTH + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [CNTWIDTH-1:0]  push_count_q, push_count_d;
    logic [CNTWIDTH-1:0]  drop_count_q, drop_count_d;

    logic not_empty;
    logic pop;
    logic push_acc;
    logic push_drop;

    // Handshake decode. A push into a full FIFO still fits when the head
    // leaves in the same cycle.
    always_comb begin
        not_empty = (count_q != '0);
        pop       = not_empty & cons.outReady;
        push_acc  = outFlag & ((count_q != FULL_CNT) | pop);
        push_drop = outFlag & ~push_acc;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        push_count_d = push_count_q;
        drop_count_d = drop_count_q;

        if (push_acc) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            push_count_d = push_count_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end

        unique case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            push_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            push_count_q <= push_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is not cleared by reset; stale entries are never visible
    // because the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (reset && push_acc) begin
            mem_q[wr_ptr_q] <= out;
        end
    end

    always_comb begin
        cons.outValid = not_empty;
        cons.outData  = not_empty ? mem_q[rd_ptr_q] : '0;
        stallOut      = (count_q >= NEAR_CNT);
        count         = count_q;
        overflow      = overflow_q;
        pushCount     = push_count_q;
        dropCount     = drop_count_q;
    end

`ifdef OUT_CHECK_EN
    logic [CNTWIDTH-1:0] check_index_q, check_index_d;
    logic                mismatch_q, mismatch_d;
    logic [CNTWIDTH-1:0] first_idx_q, first_idx_d;

    always_comb begin
        check_index_d = check_index_q;
        mismatch_d    = mismatch_q;
        first_idx_d   = first_idx_q;
        if (pop) begin
            check_index_d = check_index_q + 1'b1;
            // Only the first difference is recorded; later ones keep the index.
            if ((cons.outData != expectData) && !mismatch_q) begin
                mismatch_d  = 1'b1;
                first_idx_d = check_index_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            check_index_q <= '0;
            mismatch_q    <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            check_index_q <= check_index_d;
            mismatch_q    <= mismatch_d;
            first_idx_q   <= first_idx_d;
        end
    end

    always_comb begin
        checkIndex         = check_index_q;
        mismatch           = mismatch_q;
        firstMismatchIndex = first_idx_q;
    end
`endif

endmodule

// File: tb/tb_cpu_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_cpu_out_fifo
//   Directed bench for cpu_out_fifo (WIDTH=36, DEPTH=8). Inputs change 1 time
//   unit after the rising edge; outputs are sampled at the same point, i.e.
//   they show the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_cpu_out_fifo;

    localparam int WIDTH     = 36;
    localparam int DEPTH     = 8;
    localparam int ADDRWIDTH = 3;
    localparam int CNTWIDTH  = 16;

    logic                clock;
    logic                reset;
    logic                outFlag;
    logic [WIDTH-1:0]    out;
    logic                stallOut;
    logic [ADDRWIDTH:0]  count;
    logic                overflow;
    logic [CNTWIDTH-1:0] pushCount;
    logic [CNTWIDTH-1:0] dropCount;
`ifdef OUT_CHECK_EN
    logic [WIDTH-1:0]    expectData;
    logic [CNTWIDTH-1:0] checkIndex;
    logic                mismatch;
    logic [CNTWIDTH-1:0] firstMismatchIndex;
`endif

    int n_checks;
    int n_errors;

    cpu_out_fifo_if #(.WIDTH(WIDTH)) cons_if ();

    cpu_out_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDRWIDTH (ADDRWIDTH),
        .CNTWIDTH  (CNTWIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .outFlag   (outFlag),
        .out       (out),
        .stallOut  (stallOut),
        .cons      (cons_if),
        .count     (count),
        .overflow  (overflow),
        .pushCount (pushCount),
        .dropCount (dropCount)
`ifdef OUT_CHECK_EN
        ,
        .expectData         (expectData),
        .checkIndex         (checkIndex),
        .mismatch           (mismatch),
        .firstMismatchIndex (firstMismatchIndex)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        outFlag = 1'b0;
        cons_if.outReady = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        outFlag  = 1'b0;
        out      = '0;
        cons_if.outReady = 1'b0;
`ifdef OUT_CHECK_EN
        expectData = '0;
`endif
        step();
        step();

        // Reset state
        check_eq("rst_count",    64'(count), 0);
        check_eq("rst_valid",    64'(cons_if.outValid), 0);
        check_eq("rst_data",     64'(cons_if.outData), 0);
        check_eq("rst_overflow", 64'(overflow), 0);
        check_eq("rst_push",     64'(pushCount), 0);
        check_eq("rst_drop",     64'(dropCount), 0);
        check_eq("rst_stall",    64'(stallOut), 0);
        reset = 1'b1;

        // Push 13, 2, 1 with the consumer always ready
        cons_if.outReady = 1'b1;
        outFlag = 1'b1; out = 36'd13; step();
        check_eq("t1_valid0", 64'(cons_if.outValid), 1);
        check_eq("t1_data0",  64'(cons_if.outData), 13);
        out = 36'd2; step();
        check_eq("t1_data1",  64'(cons_if.outData), 2);
        check_eq("t1_count1", 64'(count), 1);
        out = 36'd1; step();
        check_eq("t1_data2",  64'(cons_if.outData), 1);
        outFlag = 1'b0; step();
        check_eq("t1_valid_end", 64'(cons_if.outValid), 0);
        check_eq("t1_push",      64'(pushCount), 3);
        check_eq("t1_overflow",  64'(overflow), 0);

        // Overfill with the consumer stalled: 9 words into 8 entries
        do_reset();
        for (int i = 0; i < 9; i++) begin
            outFlag = 1'b1; out = 36'(i); step();
            if (i == 5) check_eq("t2_stall_c6", 64'(stallOut), 0);
            if (i == 6) check_eq("t2_stall_c7", 64'(stallOut), 1);
            if (i == 7) check_eq("t2_count8",   64'(count), 8);
        end
        outFlag = 1'b0;
        check_eq("t2_count_after", 64'(count), 8);
        check_eq("t2_overflow",    64'(overflow), 1);
        check_eq("t2_drop",        64'(dropCount), 1);
        check_eq("t2_push",        64'(pushCount), 8);
        cons_if.outReady = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check_eq("t2_drain", 64'(cons_if.outData), 64'(j));
            step();
        end
        check_eq("t2_empty", 64'(count), 0);
        check_eq("t2_overflow_sticky", 64'(overflow), 1);

        // Push into a full FIFO while popping
        do_reset();
        for (int i = 0; i < 8; i++) begin
            outFlag = 1'b1; out = 36'(i); step();
        end
        outFlag = 1'b1; out = 36'd100; cons_if.outReady = 1'b1; step();
        outFlag = 1'b0;
        check_eq("t3_count",    64'(count), 8);
        check_eq("t3_overflow", 64'(overflow), 0);
        check_eq("t3_drop",     64'(dropCount), 0);
        for (int j = 1; j < 8; j++) begin
            check_eq("t3_drain", 64'(cons_if.outData), 64'(j));
            step();
        end
        check_eq("t3_last", 64'(cons_if.outData), 100);
        step();
        check_eq("t3_empty", 64'(count), 0);

        // Reset while holding five words and pushing
        do_reset();
        for (int i = 0; i < 5; i++) begin
            outFlag = 1'b1; out = 36'(50 + i); step();
        end
        outFlag = 1'b0;
        check_eq("t4_count5", 64'(count), 5);
        reset = 1'b0; outFlag = 1'b1; out = 36'd77; step();
        reset = 1'b1; outFlag = 1'b0;
        check_eq("t4_count",  64'(count), 0);
        check_eq("t4_valid",  64'(cons_if.outValid), 0);
        check_eq("t4_push",   64'(pushCount), 0);
        check_eq("t4_data",   64'(cons_if.outData), 0);
        step();
        check_eq("t4_not_stored", 64'(count), 0);

        // 20 words streamed through, pointers wrap
        do_reset();
        cons_if.outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            outFlag = 1'b1; out = 36'(200 + i); step();
            check_eq("t5_data",  64'(cons_if.outData), 64'(200 + i));
            check_eq("t5_count", 64'(count), 1);
        end
        outFlag = 1'b0; step();
        check_eq("t5_empty", 64'(count), 0);
        check_eq("t5_push",  64'(pushCount), 20);

`ifdef OUT_CHECK_EN
        // Output checker: third popped word differs
        do_reset();
        cons_if.outReady = 1'b1;
        outFlag = 1'b1; out = 36'd13; step();
        out = 36'd2; expectData = 36'd13; step();
        out = 36'd5; expectData = 36'd2;  step();
        check_eq("t6_no_mismatch", 64'(mismatch), 0);
        outFlag = 1'b0; expectData = 36'd1; step();
        check_eq("t6_mismatch",  64'(mismatch), 1);
        check_eq("t6_first_idx", 64'(firstMismatchIndex), 2);
        check_eq("t6_check_idx", 64'(checkIndex), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
